// File: rtl/seq_chunk_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a single carry register.
// Subtract is A + ~B + ~cin; results, cout and ovf update only on the completion edge.
module seq_chunk_addsub #(
    parameter int WIDTH = 14,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N      = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int ACC_W  = N * CHUNK;
    localparam int W_LAST = WIDTH - (N - 1) * CHUNK;
    localparam int IDXW   = (N > 1) ? $clog2(N) : 1;
    localparam int SHW    = $clog2(ACC_W) + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_next;

    // Operands are zero-padded to a whole number of chunks so the final,
    // possibly partial, chunk reports its carry at bit W_LAST of chunk_sum.
    logic [ACC_W-1:0] a_reg;
    logic [ACC_W-1:0] b_reg;
    logic [ACC_W-1:0] acc_reg;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [SHW-1:0]   base;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [ACC_W-1:0] chunk_mask;
    logic [ACC_W-1:0] acc_next;
    logic             last;
    logic             msb_cin;

    always_comb begin
        base       = SHW'(idx) * SHW'(CHUNK);
        a_chunk    = a_reg[base +: CHUNK];
        b_chunk    = b_reg[base +: CHUNK];
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
        chunk_mask = ACC_W'({CHUNK{1'b1}}) << base;
        acc_next   = (acc_reg & ~chunk_mask) | (ACC_W'(chunk_sum[CHUNK-1:0]) << base);
        last       = (idx == IDXW'(N - 1));
        // Carry into the MSB recovered from sum and operand bits at that position.
        msb_cin    = chunk_sum[W_LAST-1] ^ a_chunk[W_LAST-1] ^ b_chunk[W_LAST-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = RUN;
            RUN:  if (last)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc_reg <= '0;
            carry   <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= ACC_W'(a);
                        b_reg <= ACC_W'(b ^ {WIDTH{mode}});
                        carry <= cin ^ mode;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    carry   <= chunk_sum[CHUNK];
                    idx     <= idx + 1'b1;
                    if (last) begin
                        sum  <= acc_next[WIDTH-1:0];
                        cout <= chunk_sum[W_LAST];
                        ovf  <= msb_cin ^ chunk_sum[W_LAST];
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_addsub.sv
// Bench for seq_chunk_addsub: four instances (CHUNK = 4, 1, 5, 14) share one stimulus
// stream; each is checked for result, flags and done latency.
module tb_seq_chunk_addsub;

    localparam int W    = 14;
    localparam int NINS = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           cin = 1'b0;

    logic           busy_v [NINS];
    logic           done_v [NINS];
    logic [W-1:0]   sum_v  [NINS];
    logic           cout_v [NINS];
    logic           ovf_v  [NINS];

    int             chunk_of [NINS] = '{4, 1, 5, 14};
    int             lat_of   [NINS] = '{4, 14, 3, 1};

    logic [W+1:0]   exp_q [$];
    int             n_vec = 0;
    int             n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NINS; g++) begin : g_dut
        seq_chunk_addsub #(
            .WIDTH(W),
            .CHUNK(g == 0 ? 4 : g == 1 ? 1 : g == 2 ? 5 : 14)
        ) dut (
            .clk  (clk),
            .rst  (rst),
            .start(start),
            .mode (mode),
            .a    (a),
            .b    (b),
            .cin  (cin),
            .busy (busy_v[g]),
            .done (done_v[g]),
            .sum  (sum_v[g]),
            .cout (cout_v[g]),
            .ovf  (ovf_v[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for done on one instance, counting edges; returns -1 if it never arrives.
    task automatic wait_inst(input int i, input int max_cyc, output int lat);
        lat = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            @(posedge clk);
            #1;
            if (done_v[i]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vm,
                          input logic vc, input logic [W-1:0] es, input logic ec, input logic eo);
        int          lat   [NINS];
        logic [W-1:0] s_got [NINS];
        logic        c_got [NINS];
        logic        o_got [NINS];
        logic        overlap;
        logic [W+1:0] exp;
        exp_q.push_back({eo, ec, es});
        @(negedge clk);
        a = va; b = vb; mode = vm; cin = vc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        overlap = 1'b0;
        for (int i = 0; i < NINS; i++) lat[i] = -1;
        for (int c = 1; c <= 20; c++) begin
            for (int i = 0; i < NINS; i++) begin
                if (done_v[i] && busy_v[i]) overlap = 1'b1;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < NINS; i++) begin
                if (done_v[i] && lat[i] < 0) begin
                    lat[i]   = c;
                    s_got[i] = sum_v[i];
                    c_got[i] = cout_v[i];
                    o_got[i] = ovf_v[i];
                end
            end
        end
        exp = exp_q.pop_front();
        for (int i = 0; i < NINS; i++) begin
            check_eq($sformatf("c%0d lat %0d%s%0d", chunk_of[i], va, vm ? "-" : "+", vb), lat[i], lat_of[i]);
            check_eq($sformatf("c%0d sum %0d%s%0d", chunk_of[i], va, vm ? "-" : "+", vb), s_got[i], exp[W-1:0]);
            check_eq($sformatf("c%0d cout %0d%s%0d", chunk_of[i], va, vm ? "-" : "+", vb), c_got[i], exp[W]);
            check_eq($sformatf("c%0d ovf %0d%s%0d", chunk_of[i], va, vm ? "-" : "+", vb), o_got[i], exp[W+1]);
        end
        check_eq("done_with_busy", overlap, 1'b0);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int            lat;
        int            tmp;
        logic          seen_done;
        logic [W-1:0]  ra, rb;
        logic          rm, rc;
        int            full, sa, sb, sr;
        logic [W-1:0]  es;
        logic          ec, eo;

        // Reset state on every instance.
        #12;
        for (int i = 0; i < NINS; i++) begin
            check_eq($sformatf("c%0d reset busy", chunk_of[i]), busy_v[i], 0);
            check_eq($sformatf("c%0d reset done", chunk_of[i]), done_v[i], 0);
            check_eq($sformatf("c%0d reset sum", chunk_of[i]), sum_v[i], 0);
            check_eq($sformatf("c%0d reset flags", chunk_of[i]), {cout_v[i], ovf_v[i]}, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // Directed vectors: a, b, mode, cin -> sum, cout, ovf.
        run_op(14'd9999,  14'd1234,  1'b0, 1'b0, 14'd11233, 1'b0, 1'b0);
        run_op(14'd16383, 14'd1,     1'b0, 1'b0, 14'd0,     1'b1, 1'b0);
        run_op(14'd16383, 14'd0,     1'b0, 1'b1, 14'd0,     1'b1, 1'b0);
        run_op(14'd8191,  14'd1,     1'b0, 1'b0, 14'd8192,  1'b0, 1'b1);
        run_op(14'd8192,  14'd1,     1'b1, 1'b0, 14'd8191,  1'b1, 1'b1);
        run_op(14'd5,     14'd7,     1'b1, 1'b0, 14'd16382, 1'b0, 1'b0);
        run_op(14'd7,     14'd5,     1'b1, 1'b0, 14'd2,     1'b1, 1'b0);
        run_op(14'd7,     14'd5,     1'b1, 1'b1, 14'd1,     1'b1, 1'b0);
        run_op(14'd100,   14'd200,   1'b0, 1'b1, 14'd301,   1'b0, 1'b0);
        run_op(14'd0,     14'd0,     1'b1, 1'b1, 14'd16383, 1'b0, 1'b0);
        run_op(14'd8191,  14'd16383, 1'b1, 1'b0, 14'd8192,  1'b0, 1'b1);

        // start pulsed while busy with other operands is ignored (CHUNK=4 instance).
        @(negedge clk);
        a = 14'd9999; b = 14'd1234; mode = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        a = 14'd1; b = 14'd1; mode = 1'b1; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("busy_after_ignored_start", busy_v[0], 1);
        wait_inst(0, 10, lat);
        check_eq("ignored_start_lat", lat + 2, 4);
        check_eq("ignored_start_sum", sum_v[0], 14'd11233);

        // Start in the done cycle is accepted; its done arrives 4 cycles later.
        a = 14'd7; b = 14'd5; mode = 1'b1; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_eq("b2b_busy", busy_v[0], 1);
        check_eq("b2b_done_low", done_v[0], 0);
        wait_inst(0, 10, lat);
        check_eq("b2b_lat", lat, 4);
        check_eq("b2b_sum", sum_v[0], 14'd2);
        check_eq("b2b_cout", cout_v[0], 1);
        idle_cycles(20);

        // Reset two cycles into an operation clears outputs at once, no done pulse.
        @(negedge clk);
        a = 14'd9999; b = 14'd1234; mode = 1'b0; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_busy", busy_v[0], 0);
        check_eq("rst_done", done_v[0], 0);
        check_eq("rst_sum", sum_v[0], 0);
        check_eq("rst_cout", cout_v[0], 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done_v[0] || busy_v[0]) seen_done = 1'b1;
        end
        check_eq("rst_no_done", seen_done, 0);
        run_op(14'd7, 14'd5, 1'b1, 1'b1, 14'd1, 1'b1, 1'b0);

        // Random regression against an arithmetic model on signed/unsigned integers.
        for (int k = 0; k < 20; k++) begin
            ra = W'($urandom_range(0, 16383));
            rb = W'($urandom_range(0, 16383));
            rm = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            sa = (ra >= 14'd8192) ? int'(ra) - 16384 : int'(ra);
            sb = (rb >= 14'd8192) ? int'(rb) - 16384 : int'(rb);
            if (!rm) begin
                full = int'(ra) + int'(rb) + int'(rc);
                ec   = (full >= 16384);
                sr   = sa + sb + int'(rc);
            end else begin
                full = int'(ra) - int'(rb) - int'(rc);
                ec   = (full >= 0);
                sr   = sa - sb - int'(rc);
            end
            tmp = (full + 32768) % 16384;
            es  = W'(tmp);
            eo  = (sr > 8191) || (sr < -8192);
            run_op(ra, rb, rm, rc, es, ec, eo);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
